// File: rtl/piso_serial_tx_pkg.sv
// Shared types for the parallel-in serial-out transmitter and its matching receiver.
package piso_serial_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Counter width that stays at least one bit wide for a terminal count of 1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_serial_tx_bit_tick_gen.sv
// Bit-period divider: tick_c marks the last clock of each DIV-clock bit period.
module bit_tick_gen
  import piso_serial_tx_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam int unsigned CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt_q;
  logic [CW-1:0] div_cnt_d;

  // With DIV=1 LAST is zero, so the counter never leaves 0 and tick follows en.
  assign tick_c = en && (div_cnt_q == LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = tick_c ? '0 : div_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter: one word per valid/ready handshake, each bit
// held DIV clocks with a frame strobe and a done pulse after the last bit.
module piso_serial_tx
  import piso_serial_tx_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIV       = 1,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sframe,
  output logic             done
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sout_q, sout_d;
  logic             sframe_q, sframe_d;
  logic             done_q, done_d;
  logic             accept_c;
  logic             tick_c;

  assign din_ready = (state_q == ST_IDLE);
  assign accept_c  = din_valid && din_ready;
  assign sout      = sout_q;
  assign sframe    = sframe_q;
  assign done      = done_q;

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept_c),
    .en     (state_q == ST_SHIFT),
    .tick_c (tick_c)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sout_d    = sout_q;
    sframe_d  = sframe_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sout_d   = 1'b0;
        sframe_d = 1'b0;
        if (accept_c) begin
          shreg_d   = din;
          bit_cnt_d = '0;
          sout_d    = MSB_FIRST ? din[WIDTH-1] : din[0];
          sframe_d  = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick_c) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            sout_d    = 1'b0;
            sframe_d  = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            // The outgoing bit always sits at the end of the register nearest sout.
            bit_cnt_d = bit_cnt_q + BW'(1);
            shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, shreg_q[WIDTH-1:1]};
            sout_d    = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sout_q    <= 1'b0;
      sframe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sout_q    <= sout_d;
      sframe_q  <= sframe_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench for piso_serial_tx: three configurations (DIV=1 MSB-first,
// DIV=4 MSB-first, DIV=1 LSB-first) checked cycle by cycle against a queue model.
module tb_piso_serial_tx;

  localparam int QD = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0][7:0] din = '0;
  logic [2:0]      vld = '0;
  logic [2:0]      rdy;
  logic [2:0]      so;
  logic [2:0]      sf;
  logic [2:0]      dn;

  int unsigned chk_cnt  = 0;
  int unsigned pass_cnt = 0;
  int unsigned cyc_cnt  = 0;

  // Expected per-cycle response {ready, done, sframe, sout}; empty queue means idle.
  logic [3:0]  expq [3][QD];
  int unsigned hd [3];
  int unsigned tl [3];

  always #5 clk = ~clk;

  piso_serial_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(vld[0]),
    .din_ready(rdy[0]), .sout(so[0]), .sframe(sf[0]), .done(dn[0]));

  piso_serial_tx #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(vld[1]),
    .din_ready(rdy[1]), .sout(so[1]), .sframe(sf[1]), .done(dn[1]));

  piso_serial_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(vld[2]),
    .din_ready(rdy[2]), .sout(so[2]), .sframe(sf[2]), .done(dn[2]));

  function automatic int div_of(input int i);
    return (i == 1) ? 4 : 1;
  endfunction

  function automatic bit msb_of(input int i);
    return (i != 2);
  endfunction

  task automatic check(input int i, input logic [3:0] act, input logic [3:0] exp);
    chk_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL inst%0d cycle%0d {ready,done,sframe,sout} got %b expected %b",
               i, cyc_cnt, act, exp);
    end
  endtask

  // Frame of an accepted word: bit k/DIV of the transmit order for WIDTH*DIV cycles,
  // then one done cycle in which the block is ready again.
  task automatic push_frame(input int i, input logic [7:0] w);
    int d;
    int b;
    d = div_of(i);
    for (int k = 0; k < 8 * d; k++) begin
      b = k / d;
      expq[i][tl[i] % QD] = {1'b0, 1'b0, 1'b1, msb_of(i) ? w[7 - b] : w[b]};
      tl[i]++;
    end
    expq[i][tl[i] % QD] = 4'b1100;
    tl[i]++;
  endtask

  // Monitor: mid-cycle compare, then let the model take the handshake for the next edge.
  initial begin
    logic [3:0] act;
    logic [3:0] exp;
    for (int i = 0; i < 3; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    forever begin
      @(negedge clk);
      cyc_cnt++;
      for (int i = 0; i < 3; i++) begin
        act = {rdy[i], dn[i], sf[i], so[i]};
        if (rst) begin
          hd[i] = tl[i];
          check(i, {1'b0, act[2:0]}, 4'b0000);
        end else begin
          exp = 4'b1000;
          if (hd[i] != tl[i]) begin
            exp = expq[i][hd[i] % QD];
            hd[i]++;
          end
          check(i, act, exp);
          if (exp[3] && vld[i]) push_frame(i, din[i]);
        end
      end
    end
  end

  task automatic set_in(input int i, input logic [7:0] w, input logic v);
    din[i] = w;
    vld[i] = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] w, input int gap);
    set_in(i, w, 1'b1);
    cyc(1);
    set_in(i, 8'h00, 1'b0);
    cyc(gap);
  endtask

  initial begin
    int i;
    int hold;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    send(0, 8'hA5, 12);
    send(1, 8'h81, 36);

    // Valid held with a moving din across the 8'h3C frame; the done-cycle word follows.
    set_in(0, 8'h3C, 1'b1);
    cyc(1);
    for (int k = 0; k < 8; k++) begin
      set_in(0, 8'($urandom), 1'b1);
      cyc(1);
    end
    set_in(0, 8'h00, 1'b0);
    cyc(14);

    set_in(0, 8'hFF, 1'b1);
    cyc(1);
    set_in(0, 8'h00, 1'b1);
    cyc(9);
    set_in(0, 8'h00, 1'b0);
    cyc(12);

    // Reset three bits into 8'hF0, then a clean 8'h55.
    set_in(0, 8'hF0, 1'b1);
    cyc(1);
    set_in(0, 8'h00, 1'b0);
    cyc(3);
    rst = 1'b1;
    set_in(0, 8'hAA, 1'b1);
    cyc(2);
    set_in(0, 8'h00, 1'b0);
    rst = 1'b0;
    cyc(2);
    send(0, 8'h55, 12);

    send(2, 8'h01, 12);

    repeat (60) begin
      i = int'($urandom_range(2, 0));
      hold = int'($urandom_range(12, 1));
      for (int k = 0; k < hold; k++) begin
        set_in(i, 8'($urandom), 1'b1);
        cyc(1);
      end
      set_in(i, 8'h00, 1'b0);
      cyc(int'($urandom_range(40, 0)));
      if ($urandom_range(7, 0) == 0) begin
        rst = 1'b1;
        cyc(int'($urandom_range(2, 1)));
        rst = 1'b0;
      end
    end

    cyc(50);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
